// File: rtl/noc_harness_pkg.sv
// Shared types and helpers for the NoC traffic harness.
// Holds the scheduler state encoding and round-robin destination math.
package noc_harness_pkg;

    localparam int DEF_CNT_W  = 32;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_COOL = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

    // Lowest address that is not this node.
    function automatic int unsigned first_dest(input int unsigned self_id);
        return (self_id == 0) ? 1 : 0;
    endfunction

    // Next destination modulo n, skipping this node's own address.
    function automatic int unsigned next_dest(
        input int unsigned cur,
        input int unsigned n,
        input int unsigned self_id
    );
        int unsigned d;
        d = (cur + 1) % n;
        if (d == self_id) d = (d + 1) % n;
        return d;
    endfunction

endpackage

// File: rtl/rr_dest_gen.sv
// Round-robin destination register that never points at SELF_ID.
// Ports: clk, reset (async active-low), load (restart), adv (step), dest.
module rr_dest_gen
    import noc_harness_pkg::*;
#(
    parameter int N_NODES = 16,
    parameter int SELF_ID = 0,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              adv,
    output logic [ADDR_W-1:0] dest
);

    localparam int unsigned FIRST = first_dest(SELF_ID);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest <= ADDR_W'(FIRST);
        end else if (load) begin
            dest <= ADDR_W'(FIRST);
        end else if (adv) begin
            dest <= ADDR_W'(next_dest(32'(dest), N_NODES, SELF_ID));
        end
    end

endmodule

// File: rtl/traffic_scheduler.sv
// Per-node injection controller: SEND phase at a fixed offer rate, then
// COOLDOWN until drained or expired. Ports: clk, reset (async active-low),
// start; injection offer inj_valid/inj_dest/inj_seq with inj_ready; rcv_valid
// receive pulses; status send/busy/done/timeout; sent/rcvd/outstanding counts.
module traffic_scheduler
    import noc_harness_pkg::*;
#(
    parameter int SIM_CYCLES      = 100000,
    parameter int COOLDOWN_CYCLES = 10000,
    parameter int INJ_PERIOD      = 4,
    parameter int N_NODES         = 16,
    parameter int SELF_ID         = 0,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              inj_valid,
    output logic [ADDR_W-1:0] inj_dest,
    output logic [CNT_W-1:0]  inj_seq,
    input  logic              inj_ready,
    input  logic              rcv_valid,
    output logic              send,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  sent_count,
    output logic [CNT_W-1:0]  rcvd_count,
    output logic [CNT_W-1:0]  outstanding
);

    sched_state_e     state, state_n;
    logic [CNT_W-1:0] phase_cnt, phase_n;
    logic [CNT_W-1:0] cool_cnt, cool_n;
    logic [CNT_W-1:0] period_cnt, period_n;
    logic [CNT_W-1:0] seq_n, sent_n, rcvd_n, out_n;
    logic             valid_n, timeout_n;
    logic             hs, hold, rcv_on;
    logic             last_send, drained, expired;
    logic             dest_load;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign hs        = inj_valid & inj_ready;
    assign hold      = inj_valid & ~inj_ready;
    assign rcv_on    = rcv_valid & (state != ST_IDLE);
    assign last_send = (phase_cnt == CNT_W'(SIM_CYCLES - 1));
    assign drained   = (outstanding == '0) & ~inj_valid;
    assign expired   = (cool_cnt == CNT_W'(COOLDOWN_CYCLES - 1));

    always_comb begin
        state_n   = state;
        phase_n   = phase_cnt;
        cool_n    = cool_cnt;
        period_n  = period_cnt;
        valid_n   = inj_valid;
        seq_n     = inj_seq;
        sent_n    = sent_count;
        rcvd_n    = rcvd_count;
        out_n     = outstanding;
        timeout_n = timeout;
        dest_load = 1'b0;

        if (rcv_on) rcvd_n = sat_inc(rcvd_count);
        if (hs) begin
            sent_n = sat_inc(sent_count);
            seq_n  = sat_inc(inj_seq);
        end
        // Outstanding is frozen outside the active phases; a send and a
        // receive in the same cycle cancel, and receives floor at zero.
        if (state == ST_SEND || state == ST_COOL) begin
            if (hs && !rcv_on) begin
                out_n = sat_inc(outstanding);
            end else if (rcv_on && !hs && outstanding != '0) begin
                out_n = outstanding - CNT_W'(1);
            end
        end

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n   = ST_SEND;
                    phase_n   = '0;
                    cool_n    = '0;
                    period_n  = '0;
                    valid_n   = 1'b0;
                    seq_n     = '0;
                    sent_n    = '0;
                    rcvd_n    = '0;
                    out_n     = '0;
                    timeout_n = 1'b0;
                    dest_load = 1'b1;
                end
            end
            ST_SEND: begin
                phase_n = sat_inc(phase_cnt);
                if (hs) begin
                    period_n = CNT_W'(INJ_PERIOD - 1);
                end else if (!inj_valid && period_cnt != '0) begin
                    period_n = period_cnt - CNT_W'(1);
                end
                // Launch when the gap has elapsed; the last SEND cycle never
                // launches, so COOL only ever carries a leftover offer.
                valid_n = hold | ((period_n == '0) & ~last_send);
                if (last_send) state_n = ST_COOL;
            end
            ST_COOL: begin
                cool_n  = sat_inc(cool_cnt);
                valid_n = hold;
                if (drained) begin
                    state_n = ST_DONE;
                end else if (expired) begin
                    state_n   = ST_DONE;
                    timeout_n = 1'b1;
                    valid_n   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_cnt   <= '0;
            cool_cnt    <= '0;
            period_cnt  <= '0;
            inj_valid   <= 1'b0;
            inj_seq     <= '0;
            sent_count  <= '0;
            rcvd_count  <= '0;
            outstanding <= '0;
            timeout     <= 1'b0;
        end else begin
            phase_cnt   <= phase_n;
            cool_cnt    <= cool_n;
            period_cnt  <= period_n;
            inj_valid   <= valid_n;
            inj_seq     <= seq_n;
            sent_count  <= sent_n;
            rcvd_count  <= rcvd_n;
            outstanding <= out_n;
            timeout     <= timeout_n;
        end
    end

    rr_dest_gen #(
        .N_NODES(N_NODES),
        .SELF_ID(SELF_ID),
        .ADDR_W (ADDR_W)
    ) u_dest (
        .clk  (clk),
        .reset(reset),
        .load (dest_load),
        .adv  (hs),
        .dest (inj_dest)
    );

    assign send = (state == ST_SEND);
    assign busy = (state == ST_SEND) | (state == ST_COOL);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_traffic_scheduler.sv
// Self-checking bench for traffic_scheduler: directed scenarios plus random
// ready/receive traffic compared every cycle against a behavioural model.
module tb_traffic_scheduler;

    localparam int SIM  = 16;
    localparam int CD   = 6;
    localparam int P    = 3;
    localparam int N    = 5;
    localparam int SELF = 2;
    localparam int AW   = 3;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;
    localparam int FIRST = (SELF == 0) ? 1 : 0;

    localparam int M_IDLE = 0;
    localparam int M_SEND = 1;
    localparam int M_COOL = 2;
    localparam int M_DONE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          inj_ready = 1'b0;
    logic          rcv_valid = 1'b0;
    logic          inj_valid;
    logic [AW-1:0] inj_dest;
    logic [CW-1:0] inj_seq;
    logic          send, busy, done, timeout;
    logic [CW-1:0] sent_count, rcvd_count, outstanding;

    int checks = 0;
    int errors = 0;

    traffic_scheduler #(
        .SIM_CYCLES     (SIM),
        .COOLDOWN_CYCLES(CD),
        .INJ_PERIOD     (P),
        .N_NODES        (N),
        .SELF_ID        (SELF),
        .ADDR_W         (AW),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .inj_valid  (inj_valid),
        .inj_dest   (inj_dest),
        .inj_seq    (inj_seq),
        .inj_ready  (inj_ready),
        .rcv_valid  (rcv_valid),
        .send       (send),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .sent_count (sent_count),
        .rcvd_count (rcvd_count),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    // Behavioural model: time is counted from SEND entry, the next offer is
    // a scheduled time, and destinations are plain modular arithmetic.
    int m_mode = M_IDLE;
    int m_t = 0;
    int m_ct = 0;
    int m_next = 0;
    int m_dest = FIRST;
    int m_seq = 0;
    int m_sent = 0;
    int m_rcvd = 0;
    int m_out = 0;
    bit m_valid = 1'b0;
    bit m_to = 1'b0;

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    function automatic int adv(input int d);
        int n;
        n = (d + 1) % N;
        if (n == SELF) n = (n + 1) % N;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit hs, rv, hold, drained;
        if (!reset) begin
            m_mode = M_IDLE; m_t = 0; m_ct = 0; m_next = 0;
            m_dest = FIRST; m_seq = 0; m_sent = 0; m_rcvd = 0;
            m_out = 0; m_valid = 1'b0; m_to = 1'b0;
        end else begin
            hs = m_valid && inj_ready;
            rv = rcv_valid && (m_mode != M_IDLE);
            drained = (m_out == 0) && !m_valid;
            hold = m_valid && !hs;
            if (rv) m_rcvd = sat(m_rcvd);
            if (m_mode == M_SEND || m_mode == M_COOL) begin
                if (hs && !rv) m_out = sat(m_out);
                else if (rv && !hs && m_out > 0) m_out = m_out - 1;
            end
            if (hs) begin
                m_sent = sat(m_sent);
                m_seq = sat(m_seq);
                m_dest = adv(m_dest);
            end
            case (m_mode)
                M_SEND: begin
                    if (hs) m_next = m_t + P;
                    m_valid = hold || (m_t + 1 >= m_next && m_t + 1 < SIM);
                    if (m_t == SIM - 1) begin
                        m_mode = M_COOL;
                        m_ct = 0;
                    end else begin
                        m_t = m_t + 1;
                    end
                end
                M_COOL: begin
                    m_valid = hold;
                    if (drained) begin
                        m_mode = M_DONE;
                    end else if (m_ct == CD - 1) begin
                        m_mode = M_DONE;
                        m_to = 1'b1;
                        m_valid = 1'b0;
                    end else begin
                        m_ct = m_ct + 1;
                    end
                end
                default: begin
                    if (start) begin
                        m_mode = M_SEND; m_t = 0; m_ct = 0; m_next = 1;
                        m_dest = FIRST; m_seq = 0; m_sent = 0;
                        m_rcvd = 0; m_out = 0; m_valid = 1'b0;
                        m_to = 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("send", 32'(send), 32'(m_mode == M_SEND));
        chk("busy", 32'(busy), 32'(m_mode == M_SEND || m_mode == M_COOL));
        chk("done", 32'(done), 32'(m_mode == M_DONE));
        chk("inj_valid", 32'(inj_valid), 32'(m_valid));
        chk("inj_dest", 32'(inj_dest), 32'(m_dest));
        chk("inj_seq", 32'(inj_seq), 32'(m_seq));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("sent_count", 32'(sent_count), 32'(m_sent));
        chk("rcvd_count", 32'(rcvd_count), 32'(m_rcvd));
        chk("outstanding", 32'(outstanding), 32'(m_out));
    endtask

    // Check the current cycle, then drive this cycle's inputs.
    task automatic tick(input logic s, input logic rdy, input logic rv);
        @(negedge clk);
        check_model();
        start = s;
        inj_ready = rdy;
        rcv_valid = rv;
    endtask

    task automatic rand_tick();
        tick(1'b0, 1'($urandom % 2), 1'(($urandom % 3) == 0));
    endtask

    int send_cyc;
    int cool_cyc;

    initial begin
        // Reset state
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_dest", 32'(inj_dest), 32'(FIRST));
        chk("rst_valid", 32'(inj_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        // rcv_valid in IDLE is ignored
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        chk("idle_rcv", 32'(rcvd_count), 32'd0);

        // Back-pressure on the first offer, then spacing of the next one
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t0_valid", 32'(inj_valid), 32'd0);
        repeat (5) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("bp_valid", 32'(inj_valid), 32'd1);
            chk("bp_dest", 32'(inj_dest), 32'(FIRST));
            chk("bp_seq", 32'(inj_seq), 32'd0);
        end
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("gap1_valid", 32'(inj_valid), 32'd0);
        chk("gap1_sent", 32'(sent_count), 32'd1);
        chk("gap1_dest", 32'(inj_dest), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        chk("gap2_valid", 32'(inj_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        chk("reoffer_valid", 32'(inj_valid), 32'd1);
        chk("reoffer_seq", 32'(inj_seq), 32'd1);
        repeat (20) rand_tick();
        chk("run1_done", 32'(done), 32'd1);

        // Offer pending at SEND end, accepted 2 cycles into COOL, then expiry
        tick(1'b1, 1'b1, 1'b0);
        send_cyc = 0;
        cool_cyc = 0;
        for (int i = 0; i < SIM + CD + 2; i++) begin
            tick(1'(i == 5), 1'((i < 13) || (i >= SIM + 2)), 1'b0);
            send_cyc += int'(send);
            cool_cyc += int'(busy & ~send);
        end
        chk("send_len", 32'(send_cyc), 32'(SIM));
        chk("cool_len", 32'(cool_cyc), 32'(CD));
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_done", 32'(done), 32'd1);
        chk("to_sent", 32'(sent_count), 32'd5);
        chk("to_out", 32'(outstanding), 32'd5);

        // Late arrivals in DONE, outstanding frozen, rcvd saturates
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("late_rcvd", 32'(rcvd_count), 32'd3);
        chk("late_out", 32'(outstanding), 32'd5);
        repeat (260) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("rcvd_sat", 32'(rcvd_count), 32'(MAXC));

        // Floor at zero, simultaneous send+receive, start while busy
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        chk("floor_out", 32'(outstanding), 32'd0);
        chk("floor_rcvd", 32'(rcvd_count), 32'd1);
        repeat (5) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        chk("sim_pre_out", 32'(outstanding), 32'd2);
        tick(1'b0, 1'b1, 1'b0);
        chk("sim_out", 32'(outstanding), 32'd2);
        chk("sim_sent", 32'(sent_count), 32'd3);
        chk("sim_rcvd", 32'(rcvd_count), 32'd2);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("busy_start", 32'(sent_count), 32'd3);
        repeat (25) rand_tick();
        chk("run4_done", 32'(done), 32'd1);

        // Reset mid-SEND, then a clean restart
        tick(1'b1, 1'b0, 1'b0);
        repeat (10) rand_tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_send", 32'(send), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(inj_valid), 32'd0);
        chk("mid_rst_sent", 32'(sent_count), 32'd0);
        chk("mid_rst_dest", 32'(inj_dest), 32'(FIRST));
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("restart_sent", 32'(sent_count), 32'd0);
        chk("restart_send", 32'(send), 32'd1);
        repeat (30) rand_tick();
        chk("run5_done", 32'(done), 32'd1);

        // Fully random runs
        repeat (4) begin
            tick(1'b1, 1'b0, 1'b0);
            repeat (26) rand_tick();
            chk("rand_done", 32'(done), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
